rd_circ_buf_engine: RTL

RD_CIRC_BUF_ENGINE -- requirements
Module: rd_circ_buf_engine

---
 rtl/rd_circ_buf_engine.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rd_circ_buf_engine.sv
// rtl/rd_circ_buf_engine.sv - circular-buffer read engine: splits wrapped reads, repacks beats seamlessly
// Optional statistics counters are enabled with macro RD_CIRC_BUF_STATS_EN.
module rd_circ_buf_engine #(
  parameter int BUF_PTR_W = 12,
  parameter int DATA_W    = 256,
  parameter int FLOWID_W  = 8,
  parameter int SIZE_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          src_rd_buf_req_val,
  output logic                          src_rd_buf_req_rdy,
  input  logic [FLOWID_W-1:0]           src_rd_buf_req_flowid,
  input  logic [BUF_PTR_W-1:0]          src_rd_buf_req_offset,
  input  logic [SIZE_W-1:0]             src_rd_buf_req_size,
  output logic                          rd_buf_noc_req_val,
  input  logic                          rd_buf_noc_req_rdy,
  output logic [FLOWID_W+BUF_PTR_W-1:0] rd_buf_noc_req_addr,
  output logic [SIZE_W-1:0]             rd_buf_noc_req_size,
  input  logic                          noc_rd_buf_resp_val,
  output logic                          noc_rd_buf_resp_rdy,
  input  logic [DATA_W-1:0]             noc_rd_buf_resp_data,
  input  logic [$clog2(DATA_W/8)-1:0]   noc_rd_buf_resp_padbytes,
  output logic                          rd_buf_src_resp_val,
  input  logic                          rd_buf_src_resp_rdy,
  output logic [DATA_W-1:0]             rd_buf_src_resp_data,
  output logic [$clog2(DATA_W/8)-1:0]   rd_buf_src_resp_padbytes,
  output logic                          rd_buf_src_resp_last
`ifdef RD_CIRC_BUF_STATS_EN
  ,
  output logic [31:0]                   stat_req_cnt,
  output logic [31:0]                   stat_wrap_cnt
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int PAD_W = $clog2(BYTES);
  localparam int CNT_W = PAD_W + 1;
  localparam int CMP_W = (SIZE_W > BUF_PTR_W + 1) ? SIZE_W : BUF_PTR_W + 1;

  typedef enum logic [2:0] {IDLE, REQ_A, DATA_A, REQ_B, DATA_B, FLUSH} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_live;
  logic [FLOWID_W-1:0]     r_flowid;
  logic [BUF_PTR_W-1:0]    r_offset;
  logic [SIZE_W-1:0]       r_size_a, r_size_b, r_noc_rem, r_out_rem;
  logic                    r_split;
  logic [CNT_W-1:0]        r_cnt;
  logic [2*DATA_W-1:0]     r_hold;

  logic [BUF_PTR_W:0]      w_space;
  logic [CMP_W-1:0]        w_space_x;
  logic                    w_split;
  logic [SIZE_W-1:0]       w_size_a, w_size_b, w_need;
  logic                    w_req_fire, w_noc_fire, w_in_fire, w_out_fire;
  logic                    w_out_val, w_out_last, w_in_final, w_data_st;
  logic [CNT_W-1:0]        w_in_bytes, w_pos;
  logic [DATA_W-1:0]       w_in_data;
  logic [2*DATA_W-1:0]     w_ins, w_base;

  assign w_space   = {1'b1, {BUF_PTR_W{1'b0}}} - {1'b0, src_rd_buf_req_offset};
  assign w_space_x = CMP_W'(w_space);
  assign w_split   = w_space_x < CMP_W'(src_rd_buf_req_size);
  assign w_size_a  = w_split ? SIZE_W'(w_space_x) : src_rd_buf_req_size;
  assign w_size_b  = src_rd_buf_req_size - SIZE_W'(w_space_x);

  assign w_req_fire = src_rd_buf_req_val && src_rd_buf_req_rdy;
  assign w_noc_fire = rd_buf_noc_req_val && rd_buf_noc_req_rdy;
  assign w_in_fire  = noc_rd_buf_resp_val && noc_rd_buf_resp_rdy;
  assign w_out_fire = rd_buf_src_resp_val && rd_buf_src_resp_rdy;
  assign w_data_st  = (r_state == DATA_A) || (r_state == DATA_B);

  // An output beat is ready once a full beat, or all remaining bytes of the request, are held.
  assign w_need     = (r_out_rem < SIZE_W'(BYTES)) ? r_out_rem : SIZE_W'(BYTES);
  assign w_out_val  = (r_out_rem != '0) && (SIZE_W'(r_cnt) >= w_need);
  assign w_out_last = r_out_rem <= SIZE_W'(BYTES);

  assign w_in_bytes = CNT_W'(BYTES) - CNT_W'(noc_rd_buf_resp_padbytes);
  assign w_in_final = SIZE_W'(w_in_bytes) >= r_noc_rem;
  assign w_in_data  = noc_rd_buf_resp_data & ({DATA_W{1'b1}} << {noc_rd_buf_resp_padbytes, 3'b000});

  // Upper half of r_hold is the outgoing beat; new bytes land right behind the held ones.
  assign w_pos  = w_out_fire ? (r_cnt - CNT_W'(BYTES)) : r_cnt;
  assign w_ins  = {w_in_data, {DATA_W{1'b0}}} >> {w_pos, 3'b000};
  assign w_base = w_out_fire ? {r_hold[DATA_W-1:0], {DATA_W{1'b0}}} : r_hold;

  assign src_rd_buf_req_rdy  = (r_state == IDLE) && r_live;
  assign rd_buf_noc_req_val  = (r_state == REQ_A) || (r_state == REQ_B);
  assign rd_buf_noc_req_addr = {r_flowid, (r_state == REQ_B) ? {BUF_PTR_W{1'b0}} : r_offset};
  assign rd_buf_noc_req_size = (r_state == REQ_B) ? r_size_b : r_size_a;
  assign noc_rd_buf_resp_rdy = w_data_st && ((r_cnt < CNT_W'(BYTES)) || w_out_fire);

  assign rd_buf_src_resp_val      = w_out_val;
  assign rd_buf_src_resp_data     = r_hold[2*DATA_W-1 -: DATA_W];
  assign rd_buf_src_resp_last     = w_out_val && w_out_last;
  assign rd_buf_src_resp_padbytes = (w_out_val && w_out_last) ?
                                    PAD_W'(SIZE_W'(BYTES) - r_out_rem) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_fire) w_state_nxt = (src_rd_buf_req_size == '0) ? FLUSH : REQ_A;
      REQ_A:   if (w_noc_fire) w_state_nxt = DATA_A;
      DATA_A:  if (w_in_fire && w_in_final) w_state_nxt = r_split ? REQ_B : FLUSH;
      REQ_B:   if (w_noc_fire) w_state_nxt = DATA_B;
      DATA_B:  if (w_in_fire && w_in_final) w_state_nxt = FLUSH;
      FLUSH:   if ((r_out_rem == '0) || (w_out_fire && w_out_last)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_live    <= 1'b0;
      r_flowid  <= '0;
      r_offset  <= '0;
      r_size_a  <= '0;
      r_size_b  <= '0;
      r_split   <= 1'b0;
      r_noc_rem <= '0;
      r_out_rem <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_req_fire) begin
        r_flowid  <= src_rd_buf_req_flowid;
        r_offset  <= src_rd_buf_req_offset;
        r_size_a  <= w_size_a;
        r_size_b  <= w_size_b;
        r_split   <= w_split;
        r_out_rem <= src_rd_buf_req_size;
      end else if (w_out_fire) begin
        r_out_rem <= w_out_last ? '0 : (r_out_rem - SIZE_W'(BYTES));
      end
      if (w_noc_fire)
        r_noc_rem <= rd_buf_noc_req_size;
      else if (w_in_fire)
        r_noc_rem <= w_in_final ? '0 : (r_noc_rem - SIZE_W'(w_in_bytes));
      if (w_out_fire && w_out_last) begin
        r_hold <= '0;
        r_cnt  <= '0;
      end else begin
        r_hold <= w_base | (w_in_fire ? w_ins : '0);
        r_cnt  <= w_pos + (w_in_fire ? w_in_bytes : '0);
      end
    end
  end

`ifdef RD_CIRC_BUF_STATS_EN
  logic [31:0] r_stat_req, r_stat_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_req  <= '0;
      r_stat_wrap <= '0;
    end else if (w_req_fire) begin
      if (r_stat_req != '1) r_stat_req <= r_stat_req + 32'd1;
      if (w_split && (r_stat_wrap != '1)) r_stat_wrap <= r_stat_wrap + 32'd1;
    end
  end

  assign stat_req_cnt  = r_stat_req;
  assign stat_wrap_cnt = r_stat_wrap;
`endif

endmodule
